pio_key_debounce: RTL and testbench
===================================

# pio_key_debounce

Parametrised Avalon-MM input PIO for push-buttons and slow switches. It synchronises and debounces up to 32 inputs per channel. It captures rising and/or falling edges, selectable per bit, into a write-1-to-clear register and raises a maskable interrupt. It sits on the Nios II data bus as a drop-in successor to the fixed 2-bit key PIO, with a wider register map.

## Interface
Parameters:
- WIDTH, 2: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a new level, ≥1.
- SYNC_STAGES, 2: synchroniser flops per input, ≥2.
- IDLE_LEVEL, {WIDTH{1'b1}}: reset value of synchroniser and debounced state. Keys idle high.

Ports:
- clk  in  1  system clock; everything is in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- address  in  3  word address.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Register map (bits above WIDTH-1 read 0 and ignore writes; unmapped addresses read 0):
  - 0 DATA, RO: debounced state db.
  - 1 IRQ_MASK, RW: reset 0.
  - 2 EDGE_CAPTURE, W1C: reset 0.
  - 3 RISE_EN, RW: reset 0.
  - 4 FALL_EN, RW: reset all ones, so falling-edge capture matches the legacy PIO.
  - 5 RAW, RO: synchroniser output s.
- A write is chipselect && !write_n. Reads have no side effects.
- Synchroniser: SYNC_STAGES-deep shift register per bit, reset to IDLE_LEVEL.
- Debounce uses one counter per channel, width $clog2(DEBOUNCE_CYCLES)+1 (≥1), reset to 0. Each cycle:
  - if s==db: cnt←0.
  - else if cnt==DEBOUNCE_CYCLES-1: db←s, cnt←0.
  - else: cnt←cnt+1.
  - Any bounce back to db restarts the count. The counter never wraps.
- Edge detect: db_prev←db each cycle, reset IDLE_LEVEL.
  - rise = db & ~db_prev.
  - fall = ~db & db_prev.
  - evt = (rise & RISE_EN) | (fall & FALL_EN).
- EDGE_CAPTURE bit n update:
  - set if evt[n];
  - else clear if a W1C write has writedata[n]=1;
  - else hold.
  - Set wins when both happen in the same cycle, so no event is lost.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.
- Changing RISE_EN/FALL_EN does not alter bits already captured.
- Asserting reset_n low mid-debounce or mid-capture returns every register to its reset value immediately. No edge is generated on reset release.

## Timing
- readdata is registered with 1-cycle read latency. It is sampled from the address valid in cycle N and appears in cycle N+1. It updates every cycle and resets to 0.
- Writes take effect on the clock edge of the write cycle. A read the following cycle returns the new value.
- Input to DATA: a clean change at in_port reaches s after SYNC_STAGES edges. db updates DEBOUNCE_CYCLES edges later.
- db to capture: EDGE_CAPTURE sets 1 edge after db changes. irq rises in the same cycle as the capture bit.
- With DEBOUNCE_CYCLES=1, db follows s with 1 cycle delay and no filtering.
- Reset values of outputs: readdata=0, irq=0.

## Test plan
- Reset, then read all addresses with WIDTH=2 -> DATA=0x3, IRQ_MASK=0, EDGE_CAPTURE=0, RISE_EN=0, FALL_EN=0x3, RAW=0x3, addr 6/7=0, irq=0.
- DEBOUNCE_CYCLES=8, in_port[0] 1→0 held -> DATA[0]=0 exactly 2+8 cycles after the change. EDGE_CAPTURE=0x1 one cycle later. irq=1 only after IRQ_MASK=0x1 is written.
- in_port[0] low pulses of 7 cycles repeated, DEBOUNCE_CYCLES=8 -> DATA stays 0x3, EDGE_CAPTURE stays 0, no irq.
- RISE_EN=0x2, FALL_EN=0: in_port[1] 1→0→1, each level held 20 cycles -> capture sets only on the release. EDGE_CAPTURE=0x2.
- EDGE_CAPTURE=0x3, write 0x1 to addr 2 -> reads 0x2. Write 0x2 in the same cycle as a new bit-1 event -> bit 1 stays 1.
- Assert reset_n low during a debounce count and with irq=1 -> irq=0 immediately. After release, DATA=IDLE_LEVEL and no spurious capture.

Source files
------------

// File: rtl/pio_key_debounce.sv
// pio_key_debounce: Avalon-MM key PIO with sync, per-bit debounce, edge capture and irq (clk, reset_n, chipselect, address, write_n, writedata, readdata, in_port, irq)
module pio_key_debounce #(
  parameter int WIDTH = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0] s, db, db_prev, mask, cap, rise_en, fall_en, evt, wd, clr, rd_sel;
  logic wr;
  always_comb begin
    s = sync[SYNC_STAGES-1];
    wr = chipselect && !write_n;
    wd = writedata[WIDTH-1:0];
    evt = (db & ~db_prev & rise_en) | (~db & db_prev & fall_en);
    clr = (wr && address == 3'd2) ? wd : '0;
    rd_sel = address == 3'd0 ? db :
             address == 3'd1 ? mask :
             address == 3'd2 ? cap :
             address == 3'd3 ? rise_en :
             address == 3'd4 ? fall_en :
             address == 3'd5 ? s : '0;
    irq = |(cap & mask);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt <= '0;
      db <= IDLE_LEVEL;
      db_prev <= IDLE_LEVEL;
      mask <= '0;
      cap <= '0;
      rise_en <= '0;
      fall_en <= '1;
      readdata <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_port};
      for (int n = 0; n < WIDTH; n++)
        if (s[n] == db[n]) cnt[n] <= '0;
        else if (cnt[n] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[n] <= s[n];
          cnt[n] <= '0;
        end else cnt[n] <= cnt[n] + CW'(1);
      db_prev <= db;
      cap <= evt | (cap & ~clr);
      if (wr && address == 3'd1) mask <= wd;
      if (wr && address == 3'd3) rise_en <= wd;
      if (wr && address == 3'd4) fall_en <= wd;
      readdata <= 32'(rd_sel);
    end
endmodule

// File: tb/tb_pio_key_debounce.sv
// tb_pio_key_debounce: directed self-checking bench for pio_key_debounce
module tb_pio_key_debounce;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1, irq;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata, d;
  logic [1:0] in_port = 2'b11;
  int n_checks = 0, n_fail = 0;
  pio_key_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq));
  always #5 clk = ~clk;
  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    chipselect = 1; address = a; write_n = 1;
    @(posedge clk); #1;
    v = readdata;
    chipselect = 0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    chipselect = 1; address = a; write_n = 0; writedata = v;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1;
  endtask
  task automatic test_reset;
    logic [31:0] exp [8] = '{32'h3, 0, 0, 0, 32'h3, 32'h3, 0, 0};
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (readdata !== 0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", readdata); end
    reset_n = 1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      n_checks++;
      if (d !== exp[a]) begin n_fail++; $display("FAIL reset_addr%0d got %h want %h", a, d, exp[a]); end
    end
    n_checks++;
    if (irq !== 0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
  endtask
  task automatic test_debounce;
    @(negedge clk);
    in_port[0] = 0; address = 0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        n_checks++;
        if (readdata[0] !== 1'b1) begin n_fail++; $display("FAIL db_early got %b want 1", readdata[0]); end
      end
      if (k == 11) begin
        n_checks++;
        if (readdata[0] !== 1'b0) begin n_fail++; $display("FAIL db_latency got %b want 0", readdata[0]); end
      end
    end
    rd(2, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL fall_capture got %h want 1", d); end
    n_checks++;
    if (irq !== 0) begin n_fail++; $display("FAIL irq_masked got %b want 0", irq); end
    wr(1, 32'h1);
    n_checks++;
    if (irq !== 1) begin n_fail++; $display("FAIL irq_unmasked got %b want 1", irq); end
    wr(2, 32'h1);
    n_checks++;
    if (irq !== 0) begin n_fail++; $display("FAIL irq_cleared got %b want 0", irq); end
    in_port[0] = 1;
    repeat (20) @(posedge clk);
    rd(2, d);
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL no_rise_capture got %h want 0", d); end
  endtask
  task automatic test_glitch;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk); in_port[0] = 0;
      repeat (7) @(posedge clk);
      @(negedge clk); in_port[0] = 1;
      repeat (6) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    rd(0, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL glitch_data got %h want 3", d); end
    rd(2, d);
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL glitch_capture got %h want 0", d); end
    n_checks++;
    if (irq !== 0) begin n_fail++; $display("FAIL glitch_irq got %b want 0", irq); end
  endtask
  task automatic test_rise;
    wr(3, 32'h2);
    wr(4, 32'h0);
    @(negedge clk); in_port[1] = 0;
    repeat (20) @(posedge clk);
    rd(2, d);
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL rise_press got %h want 0", d); end
    @(negedge clk); in_port[1] = 1;
    repeat (20) @(posedge clk);
    rd(2, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL rise_release got %h want 2", d); end
    n_checks++;
    if (irq !== 0) begin n_fail++; $display("FAIL rise_irq_masked got %b want 0", irq); end
  endtask
  task automatic test_w1c;
    wr(3, 32'h0);
    wr(4, 32'h3);
    @(negedge clk); in_port = 2'b00;
    repeat (20) @(posedge clk);
    rd(2, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL w1c_setup got %h want 3", d); end
    wr(2, 32'h1);
    rd(2, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL w1c_bit0 got %h want 2", d); end
    wr(2, 32'h2);
    rd(2, d);
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL w1c_bit1 got %h want 0", d); end
    wr(3, 32'h2);
    @(negedge clk); in_port[1] = 1;
    repeat (10) @(posedge clk);
    wr(2, 32'h2);
    rd(2, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL set_wins got %h want 2", d); end
    wr(1, 32'h3);
    n_checks++;
    if (irq !== 1) begin n_fail++; $display("FAIL irq_bit1 got %b want 1", irq); end
  endtask
  task automatic test_reset_mid;
    @(negedge clk); in_port = 2'b11;
    repeat (5) @(posedge clk);
    @(negedge clk); reset_n = 0;
    #1;
    n_checks++;
    if (irq !== 0) begin n_fail++; $display("FAIL async_irq got %b want 0", irq); end
    n_checks++;
    if (readdata !== 0) begin n_fail++; $display("FAIL async_readdata got %h want 0", readdata); end
    @(negedge clk); reset_n = 1;
    repeat (20) @(posedge clk);
    rd(0, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL post_reset_data got %h want 3", d); end
    rd(2, d);
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL post_reset_capture got %h want 0", d); end
    rd(4, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL post_reset_fall_en got %h want 3", d); end
    rd(1, d);
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL post_reset_mask got %h want 0", d); end
  endtask
  initial begin
    test_reset;
    test_debounce;
    test_glitch;
    test_rise;
    test_w1c;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
